// File: rtl/e203_subsys_clkdiv_ctrl.sv
// Runtime reconfiguration sequencer for the subsystem PLL clock divider.
// It quiesces the consumer, applies the new div/divby1, waits for settle and lock, then releases.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a request; the divider runs on the current ratio
// HOLD    | hold_req asserted; waiting up to ACK_TMO cycles for hold_ack
// APPLY   | single cycle; the pending ratio loads at its closing edge
// SETTLE  | new ratio is live; waiting SETTLE_CYC cycles and for pll_lock
// RELEASE | hold_req dropped; waiting for the consumer to drop hold_ack
// DONE    | one-cycle cfg_done pulse
// ERR     | one-cycle cfg_err pulse; the ratio is left unchanged
module e203_subsys_clkdiv_ctrl #(
  parameter logic [5:0] DIV_RST    = 6'd0,
  parameter logic       DIVBY1_RST = 1'b1,
  parameter int         SETTLE_CYC = 16,
  parameter int         ACK_TMO    = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_div,
  input  logic       cfg_divby1,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic       hold_req,
  input  logic       hold_ack,
  input  logic       pll_lock,
  output logic [5:0] div,
  output logic       divby1,
  output logic       busy
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] ACK_LAST    = 8'(ACK_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_APPLY, S_SETTLE, S_RELEASE, S_DONE, S_ERR
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [5:0] pend_div_q, pend_div_d;
  logic       pend_divby1_q, pend_divby1_d;
  logic [5:0] div_q, div_d;
  logic       divby1_q, divby1_d;
  logic       req_is_noop;

  // When both sides are bypassed the divide value is irrelevant.
  assign req_is_noop = (cfg_divby1 == divby1_q) && (cfg_divby1 || (cfg_div == div_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      pend_div_q    <= 6'd0;
      pend_divby1_q <= 1'b0;
      div_q         <= DIV_RST;
      divby1_q      <= DIVBY1_RST;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_div_q    <= pend_div_d;
      pend_divby1_q <= pend_divby1_d;
      div_q         <= div_d;
      divby1_q      <= divby1_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_div_d    = pend_div_q;
    pend_divby1_d = pend_divby1_q;
    div_d         = div_q;
    divby1_d      = divby1_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          pend_div_d    = cfg_div;
          pend_divby1_d = cfg_divby1;
          cnt_d         = 8'd0;
          state_d       = req_is_noop ? S_DONE : S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_ack) begin
          state_d = S_APPLY;
        end else if (cnt_q == ACK_LAST) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_APPLY: begin
        div_d    = pend_div_q;
        divby1_d = pend_divby1_q;
        cnt_d    = 8'd0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        // Counter saturates so a late lock still exits after the minimum settle time.
        if (cnt_q == SETTLE_LAST) begin
          if (pll_lock) state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RELEASE: begin
        if (!hold_ack) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign hold_req  = (state_q == S_HOLD) || (state_q == S_APPLY) || (state_q == S_SETTLE);
  assign cfg_done  = (state_q == S_DONE);
  assign cfg_err   = (state_q == S_ERR);
  assign div       = div_q;
  assign divby1    = divby1_q;

endmodule

// File: tb/tb_e203_subsys_clkdiv_ctrl.sv
// Directed bench for e203_subsys_clkdiv_ctrl with SETTLE_CYC=4 and ACK_TMO=8.
module tb_e203_subsys_clkdiv_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_div;
  logic       cfg_divby1;
  logic       cfg_done;
  logic       cfg_err;
  logic       hold_req;
  logic       hold_ack;
  logic       pll_lock;
  logic [5:0] div;
  logic       divby1;
  logic       busy;

  int checks = 0;
  int failures = 0;

  e203_subsys_clkdiv_ctrl #(
    .DIV_RST(6'd0), .DIVBY1_RST(1'b1), .SETTLE_CYC(4), .ACK_TMO(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div(cfg_div), .cfg_divby1(cfg_divby1),
    .cfg_done(cfg_done), .cfg_err(cfg_err),
    .hold_req(hold_req), .hold_ack(hold_ack), .pll_lock(pll_lock),
    .div(div), .divby1(divby1), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Each tick lands on the falling edge: outputs show the current cycle, inputs set here are sampled next rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_div = 6'd0; cfg_divby1 = 1'b0;
    hold_ack = 1'b0; pll_lock = 1'b1;
    tick(3);
    rst_n = 1'b1;
    check_eq("rst_div", {2'b0, div}, 8'd0);
    check_eq("rst_divby1", {7'b0, divby1}, 8'd1);
    check_eq("rst_ready", {7'b0, cfg_ready}, 8'd1);
    check_eq("rst_hold", {7'b0, hold_req}, 8'd0);
    check_eq("rst_busy", {7'b0, busy}, 8'd0);

    // No-op while bypassed: div differs but is ignored.
    cfg_valid = 1'b1; cfg_div = 6'd5; cfg_divby1 = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check_eq("noop_byp_done", {7'b0, cfg_done}, 8'd1);
    check_eq("noop_byp_hold", {7'b0, hold_req}, 8'd0);
    tick();
    check_eq("noop_byp_idle", {7'b0, cfg_ready}, 8'd1);
    check_eq("noop_byp_div", {2'b0, div}, 8'd0);

    // Normal change: cycle T is this IDLE cycle.
    cfg_valid = 1'b1; cfg_div = 6'd3; cfg_divby1 = 1'b0;
    tick();                                   // T+1 HOLD
    cfg_valid = 1'b0;
    check_eq("chg_hold_t1", {7'b0, hold_req}, 8'd1);
    check_eq("chg_ready_t1", {7'b0, cfg_ready}, 8'd0);
    tick();                                   // T+2
    hold_ack = 1'b1;
    tick();                                   // T+3 APPLY
    check_eq("chg_div_apply", {2'b0, div}, 8'd0);
    check_eq("chg_divby1_apply", {7'b0, divby1}, 8'd1);
    tick();                                   // T+4 SETTLE
    check_eq("chg_div_t4", {2'b0, div}, 8'd3);
    check_eq("chg_divby1_t4", {7'b0, divby1}, 8'd0);
    tick(3);                                  // T+7
    check_eq("chg_hold_t7", {7'b0, hold_req}, 8'd1);
    tick();                                   // T+8 RELEASE
    check_eq("chg_hold_t8", {7'b0, hold_req}, 8'd0);
    check_eq("chg_done_t8", {7'b0, cfg_done}, 8'd0);
    hold_ack = 1'b0;
    tick();                                   // T+9 DONE
    check_eq("chg_done_t9", {7'b0, cfg_done}, 8'd1);
    check_eq("chg_err_t9", {7'b0, cfg_err}, 8'd0);
    tick();                                   // T+10
    check_eq("chg_ready_t10", {7'b0, cfg_ready}, 8'd1);
    check_eq("chg_done_t10", {7'b0, cfg_done}, 8'd0);

    // No-op with matching div.
    cfg_valid = 1'b1; cfg_div = 6'd3; cfg_divby1 = 1'b0;
    tick();
    cfg_valid = 1'b0;
    check_eq("noop_done", {7'b0, cfg_done}, 8'd1);
    check_eq("noop_hold", {7'b0, hold_req}, 8'd0);
    check_eq("noop_busy", {7'b0, busy}, 8'd1);
    tick();
    check_eq("noop_busy_end", {7'b0, busy}, 8'd0);

    // Timeout: 8 HOLD cycles without ack.
    cfg_valid = 1'b1; cfg_div = 6'd7; cfg_divby1 = 1'b0;
    tick();
    cfg_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check_eq($sformatf("tmo_hold_%0d", i), {6'b0, hold_req, cfg_err}, 8'b10);
      if (i < 8) tick();
    end
    tick();                                   // T+9 ERR
    check_eq("tmo_err", {7'b0, cfg_err}, 8'd1);
    check_eq("tmo_done", {7'b0, cfg_done}, 8'd0);
    check_eq("tmo_hold_off", {7'b0, hold_req}, 8'd0);
    check_eq("tmo_div", {2'b0, div}, 8'd3);
    tick();
    check_eq("tmo_idle", {7'b0, cfg_ready}, 8'd1);

    // Ack on the last HOLD cycle wins, then a 20-cycle lock stall.
    pll_lock = 1'b0;
    cfg_valid = 1'b1; cfg_div = 6'd7; cfg_divby1 = 1'b0;
    tick();                                   // T+1
    cfg_valid = 1'b0;
    tick(7);                                  // T+8
    hold_ack = 1'b1;
    tick();                                   // T+9 APPLY
    check_eq("late_ack_noerr", {7'b0, cfg_err}, 8'd0);
    check_eq("late_ack_hold", {7'b0, hold_req}, 8'd1);
    tick();
    check_eq("late_ack_div", {2'b0, div}, 8'd7);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq($sformatf("stall_%0d", i), {6'b0, hold_req, cfg_done}, 8'b10);
    end
    pll_lock = 1'b1;
    tick();
    check_eq("stall_release", {7'b0, hold_req}, 8'd0);
    hold_ack = 1'b0;
    tick();
    check_eq("stall_done", {7'b0, cfg_done}, 8'd1);
    tick();

    // Reset in the middle of SETTLE.
    pll_lock = 1'b0;
    cfg_valid = 1'b1; cfg_div = 6'd9; cfg_divby1 = 1'b0;
    tick();
    cfg_valid = 1'b0;
    hold_ack = 1'b1;
    tick(3);                                  // SETTLE, div already 9
    check_eq("mid_div9", {2'b0, div}, 8'd9);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    hold_ack = 1'b0; pll_lock = 1'b1;
    check_eq("mid_rst_div", {2'b0, div}, 8'd0);
    check_eq("mid_rst_divby1", {7'b0, divby1}, 8'd1);
    check_eq("mid_rst_hold", {7'b0, hold_req}, 8'd0);
    check_eq("mid_rst_ready", {7'b0, cfg_ready}, 8'd1);
    check_eq("mid_rst_busy", {7'b0, busy}, 8'd0);

    // Back-to-back with cfg_valid held high; consumer acks while hold_req is high.
    cfg_valid = 1'b1; cfg_div = 6'd5; cfg_divby1 = 1'b0;
    begin
      int dones = 0;
      int cyc = 0;
      logic prev_done = 1'b0;
      while (dones < 2 && cyc < 200) begin
        tick();
        cyc++;
        hold_ack = hold_req;
        check_eq("b2b_ready_busy", {7'b0, cfg_ready & busy}, 8'd0);
        if (prev_done) begin
          check_eq("b2b_idle_after_done", {7'b0, cfg_ready}, 8'd1);
          if (dones == 1) cfg_div = 6'd6;
        end
        if (cfg_done) begin
          dones++;
          check_eq($sformatf("b2b_div_%0d", dones), {2'b0, div}, (dones == 1) ? 8'd5 : 8'd6);
        end
        prev_done = cfg_done;
        if (dones == 1 && !cfg_done && !cfg_ready && prev_done == 1'b0 && cyc > 0 && busy && hold_req && div == 6'd5)
          cfg_valid = 1'b1;
      end
      check_eq("b2b_two_dones", 8'(dones), 8'd2);
      cfg_valid = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
